// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: feeds one full-adder cell LSB first and collects sum/carry.
// Optional SERIAL_ADD_OVF_EN adds a registered signed-overflow output, ovf.

module fac (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic z,
   output logic co
);
   assign z  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_ctrl #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic         ovf
`endif
);
   localparam int unsigned CW = $clog2(W) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic [1:0]    state_q;
   logic [W-1:0]  a_sh_q;
   logic [W-1:0]  b_sh_q;
   logic [W-1:0]  sum_sh_q;
   logic [W-1:0]  sum_q;
   logic          carry_q;
   logic          cout_q;
   logic [CW-1:0] cnt_q;
   logic          fa_z;
   logic          fa_co;
`ifdef SERIAL_ADD_OVF_EN
   logic          ovf_q;
`endif

   fac u_fac (
      .x  (a_sh_q[0]),
      .y  (b_sh_q[0]),
      .ci (carry_q),
      .z  (fa_z),
      .co (fa_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_sh_q  <= a;
                  b_sh_q  <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_sh_q   <= {1'b0, a_sh_q[W-1:1]};
               b_sh_q   <= {1'b0, b_sh_q[W-1:1]};
               sum_sh_q <= {fa_z, sum_sh_q[W-1:1]};
               carry_q  <= fa_co;
               cnt_q    <= cnt_q + 1'b1;
               // Final bit: publish the result; carry_q here is the carry into the MSB.
               if (cnt_q == LAST) begin
                  sum_q   <= {fa_z, sum_sh_q[W-1:1]};
                  cout_q  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                  ovf_q   <= carry_q ^ fa_co;
`endif
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl at W=8 (SERIAL_ADD_OVF_EN aware).

module tb_serial_add_ctrl;
   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int checks;
   int failures;

   serial_add_ctrl #(
      .W (W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one addition; optionally pokes a second start at RUN cycle poke_cyc (0 = none).
   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         input logic [W-1:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf, input int poke_cyc, input string tag);
      int cycles;
      int busy_cnt;
      @(negedge clk);
      a     = va;
      b     = vb;
      cin   = vc;
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      cycles   = 0;
      busy_cnt = busy ? 1 : 0;
      while (!done && cycles < 40) begin
         if (poke_cyc != 0 && cycles + 1 == poke_cyc) begin
            start = 1'b1;
            a     = 8'h01;
            b     = 8'h01;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         cycles++;
         if (busy) busy_cnt++;
      end
      start = 1'b0;
      check({tag, "_latency"}, cycles, 32'd8);
      check({tag, "_busy_cycles"}, busy_cnt, 32'd9);
      check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_sum});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
`ifdef SERIAL_ADD_OVF_EN
      check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`else
      if (exp_ovf) begin end
`endif
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
      check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
      check({tag, "_sum_held"}, {24'd0, sum}, {24'd0, exp_sum});
   endtask

   initial begin
      logic [W:0]   tot;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rovf;
      int           cyc;
      int           last_done;
      int           pulses;
      int           seen_done;

      checks   = 0;
      failures = 0;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      rst      = 1'b1;
      #23;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_sum", {24'd0, sum}, 32'd0);
      check("reset_cout", {31'd0, cout}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0, "add_0f_01");
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, "add_ff_01");
      run_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 3, "add_aa_55_poke");
      run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, "add_7f_01");

      // Abort mid-RUN with an asynchronous reset.
      @(negedge clk);
      a     = 8'hFF;
      b     = 8'hFF;
      cin   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_sum", {24'd0, sum}, 32'd0);
      check("abort_cout", {31'd0, cout}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done || busy) seen_done++;
      end
      check("abort_no_done", seen_done, 32'd0);
      run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 0, "after_abort");

      // Start held high: back-to-back operations every W+2 cycles.
      @(negedge clk);
      a         = 8'h10;
      b         = 8'h20;
      cin       = 1'b0;
      start     = 1'b1;
      cyc       = 0;
      last_done = -1;
      pulses    = 0;
      while (pulses < 3 && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) begin
            check("b2b_sum", {24'd0, sum}, 32'h30);
            if (last_done >= 0) check("b2b_spacing", cyc - last_done, 32'd10);
            last_done = cyc;
            pulses++;
         end
      end
      check("b2b_pulses", pulses, 32'd3);
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("b2b_idle", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 256; i++) begin
         ra   = W'($urandom);
         rb   = W'($urandom);
         rc   = 1'($urandom);
         tot  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         rovf = (ra[W-1] == rb[W-1]) && (tot[W-1] != ra[W-1]);
         run_op(ra, rb, rc, tot[W-1:0], tot[W], rovf, 0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
